switch_ingress_tagger: RTL and testbench

- Per-port ingress stage placed in front of each switch_crossbar input.
- Accepts untagged Ethernet frames on AXI-Stream and extracts the destination MAC from the first beat.
- Looks the MAC up in a programmable forwarding table and drives a one-hot/multi-hot RADIX-wide tdest that is held constant for the whole frame.
- This produces exactly the tdest encoding the crossbar consumes: bit m set means deliver to output m.

---
 rtl/switch_ingress_tagger_pkg.sv | 21 ++
 rtl/switch_ingress_tagger_if.sv | 29 ++
 rtl/switch_ingress_tagger_fwd_table.sv | 74 +++++++
 rtl/switch_ingress_tagger.sv | 233 +++++++++++++++++++++++
 tb/tb_switch_ingress_tagger.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_ingress_tagger_pkg.sv
// Shared definitions for the switch ingress tagger: FSM encoding, MAC layout
// constants and the keep pattern a single-beat frame must carry to hold a DA.
package switch_pkg;

    localparam int MAC_WIDTH = 48;

    // I/G bit of the destination MAC (first octet, LSB): set for group/broadcast.
    localparam int GROUP_BIT = 0;

    // A last beat must carry at least the six DA octets.
    localparam logic [5:0] RUNT_KEEP_MASK = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_HEAD,
        ST_BODY,
        ST_DROP
    } state_t;

endpackage

// File: rtl/switch_ingress_tagger_if.sv
// AXI-Stream bundle used on both sides of the ingress tagger. tdest is
// carried on both sides so one interface type serves input and output.
interface switch_ingress_tagger_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 17,
    parameter int DEST_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/switch_ingress_tagger_fwd_table.sv
// Programmable forwarding table: TABLE_DEPTH entries of {valid, MAC, port
// mask}. Writes land at the clock edge; the lookup is purely combinational
// against the registered contents, so a write never affects a lookup made in
// the same cycle. The lowest-index valid match wins.
module switch_fwd_table
    import switch_pkg::*;
#(
    parameter int RADIX            = 4,
    parameter int TABLE_DEPTH      = 8,
    parameter int TABLE_ADDR_WIDTH = $clog2(TABLE_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [TABLE_ADDR_WIDTH-1:0] wr_addr,
    input  logic                        wr_valid,
    input  logic [MAC_WIDTH-1:0]        wr_mac,
    input  logic [RADIX-1:0]            wr_mask,
    input  logic [MAC_WIDTH-1:0]        lookup_mac,
    output logic                        hit,
    output logic [RADIX-1:0]            hit_mask
);

    logic                 valid_q [TABLE_DEPTH];
    logic                 valid_d [TABLE_DEPTH];
    logic [MAC_WIDTH-1:0] mac_q   [TABLE_DEPTH];
    logic [MAC_WIDTH-1:0] mac_d   [TABLE_DEPTH];
    logic [RADIX-1:0]     mask_q  [TABLE_DEPTH];
    logic [RADIX-1:0]     mask_d  [TABLE_DEPTH];

    // Write port: update the addressed entry.
    always_comb begin
        valid_d = valid_q;
        mac_d   = mac_q;
        mask_d  = mask_q;
        if (wr_en) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                if (wr_addr == TABLE_ADDR_WIDTH'(i)) begin
                    valid_d[i] = wr_valid;
                    mac_d[i]   = wr_mac;
                    mask_d[i]  = wr_mask;
                end
            end
        end
    end

    // Entry storage; reset invalidates every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                mac_q[i]   <= '0;
                mask_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            mac_q   <= mac_d;
            mask_q  <= mask_d;
        end
    end

    // Parallel compare; scanning downwards lets the lowest index win.
    always_comb begin
        hit      = 1'b0;
        hit_mask = '0;
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (mac_q[i] == lookup_mac)) begin
                hit      = 1'b1;
                hit_mask = mask_q[i];
            end
        end
    end

endmodule

// File: rtl/switch_ingress_tagger.sv
// Per-port ingress tagger: holds the first beat of each frame, looks its
// destination MAC up in the forwarding table and emits the frame with a
// multi-hot tdest (bit m = deliver to crossbar output m) that stays constant
// for the whole frame. Body beats pass straight through.
// Optional build macro SWITCH_INGRESS_TAGGER_STATS_EN adds saturating
// per-frame hit/flood/drop counters.
//
// state  | meaning
// IDLE   | ready for a new frame; first beat is captured into the head register
// LOOKUP | one cycle: table lookup on the held DA, runt and hairpin checks
// HEAD   | held first beat presented on m_axis with the new tdest
// BODY   | remaining beats forwarded combinationally until tlast
// DROP   | discarded frame: sink beats until tlast
module switch_ingress_tagger
    import switch_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH  = 64,
    parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_ID_WIDTH    = 8,
    parameter int AXIS_USER_WIDTH  = 17,
    parameter int RADIX            = 4,
    parameter int PORT_INDEX       = 0,
    parameter int TABLE_DEPTH      = 8,
    parameter int TABLE_ADDR_WIDTH = $clog2(TABLE_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    switch_ingress_tagger_if.slave      s_axis,
    switch_ingress_tagger_if.master     m_axis,
    input  logic                        cfg_wr_en,
    input  logic [TABLE_ADDR_WIDTH-1:0] cfg_addr,
    input  logic                        cfg_valid,
    input  logic [MAC_WIDTH-1:0]        cfg_mac,
    input  logic [RADIX-1:0]            cfg_mask
`ifdef SWITCH_INGRESS_TAGGER_STATS_EN
    ,
    output logic [31:0]                 stat_hit,
    output logic [31:0]                 stat_flood,
    output logic [31:0]                 stat_drop
`endif
);

    localparam logic [RADIX-1:0] PORT_BIT = RADIX'(1) << PORT_INDEX;

    state_t                     state_q, state_d;
    logic [AXIS_DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [AXIS_KEEP_WIDTH-1:0] head_keep_q, head_keep_d;
    logic                       head_last_q, head_last_d;
    logic [AXIS_ID_WIDTH-1:0]   head_id_q, head_id_d;
    logic [AXIS_USER_WIDTH-1:0] head_user_q, head_user_d;
    logic [RADIX-1:0]           tdest_q, tdest_d;

    logic                       tbl_hit;
    logic [RADIX-1:0]           tbl_mask;
    logic                       is_group;
    logic                       runt;
    logic [RADIX-1:0]           final_mask;
    logic                       frame_drop;

    logic                       s_ready;
    logic                       m_valid;
    logic [AXIS_DATA_WIDTH-1:0] m_data;
    logic [AXIS_KEEP_WIDTH-1:0] m_keep;
    logic                       m_last;
    logic [AXIS_ID_WIDTH-1:0]   m_id;
    logic [AXIS_USER_WIDTH-1:0] m_user;

    switch_fwd_table #(
        .RADIX            (RADIX),
        .TABLE_DEPTH      (TABLE_DEPTH),
        .TABLE_ADDR_WIDTH (TABLE_ADDR_WIDTH)
    ) u_fwd_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (cfg_wr_en),
        .wr_addr    (cfg_addr),
        .wr_valid   (cfg_valid),
        .wr_mac     (cfg_mac),
        .wr_mask    (cfg_mask),
        .lookup_mac (head_data_q[MAC_WIDTH-1:0]),
        .hit        (tbl_hit),
        .hit_mask   (tbl_mask)
    );

    // Forwarding decision for the held head beat; only consumed in LOOKUP.
    always_comb begin
        is_group   = head_data_q[GROUP_BIT];
        runt       = head_last_q && (head_keep_q[5:0] != RUNT_KEEP_MASK);
        final_mask = ((is_group || !tbl_hit) ? {RADIX{1'b1}} : tbl_mask) & ~PORT_BIT;
        frame_drop = runt || (final_mask == '0);
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_keep_d = head_keep_q;
        head_last_d = head_last_q;
        head_id_d   = head_id_q;
        head_user_d = head_user_q;
        tdest_d     = tdest_q;

        s_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = head_data_q;
        m_keep  = head_keep_q;
        m_last  = head_last_q;
        m_id    = head_id_q;
        m_user  = head_user_q;

        case (state_q)
            ST_IDLE: begin
                s_ready = 1'b1;
                if (s_axis.tvalid) begin
                    head_data_d = s_axis.tdata;
                    head_keep_d = s_axis.tkeep;
                    head_last_d = s_axis.tlast;
                    head_id_d   = s_axis.tid;
                    head_user_d = s_axis.tuser;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                // A runt is always a last beat, so it falls back to IDLE here.
                if (frame_drop) begin
                    state_d = head_last_q ? ST_IDLE : ST_DROP;
                end else begin
                    tdest_d = final_mask;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                m_valid = 1'b1;
                if (m_axis.tready) begin
                    state_d = head_last_q ? ST_IDLE : ST_BODY;
                end
            end
            ST_BODY: begin
                s_ready = m_axis.tready;
                m_valid = s_axis.tvalid;
                m_data  = s_axis.tdata;
                m_keep  = s_axis.tkeep;
                m_last  = s_axis.tlast;
                m_id    = s_axis.tid;
                m_user  = s_axis.tuser;
                if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_ready = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Both handshake outputs are held low while reset is asserted.
        s_ready = s_ready && rst_n;
        m_valid = m_valid && rst_n;
    end

    // State, head-beat and tdest registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            head_data_q <= '0;
            head_keep_q <= '0;
            head_last_q <= 1'b0;
            head_id_q   <= '0;
            head_user_q <= '0;
            tdest_q     <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_keep_q <= head_keep_d;
            head_last_q <= head_last_d;
            head_id_q   <= head_id_d;
            head_user_q <= head_user_d;
            tdest_q     <= tdest_d;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_data;
    assign m_axis.tkeep  = m_keep;
    assign m_axis.tlast  = m_last;
    assign m_axis.tid    = m_id;
    assign m_axis.tuser  = m_user;
    assign m_axis.tdest  = tdest_q;

`ifdef SWITCH_INGRESS_TAGGER_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] flood_cnt_q, flood_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Classify each frame once as it leaves LOOKUP; counters saturate.
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        flood_cnt_d = flood_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (state_q == ST_LOOKUP) begin
            if (frame_drop) begin
                if (drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;
            end else if (tbl_hit && !is_group) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                if (flood_cnt_q != 32'hFFFF_FFFF) flood_cnt_d = flood_cnt_q + 32'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q   <= '0;
            flood_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            flood_cnt_q <= flood_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign stat_hit   = hit_cnt_q;
    assign stat_flood = flood_cnt_q;
    assign stat_drop  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_switch_ingress_tagger.sv
// Directed bench for switch_ingress_tagger: two instances (PORT_INDEX 0 and 1)
// share the config bus; a select bit steers frames to one of them.
module tb_switch_ingress_tagger;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int IW = 8;
    localparam int UW = 17;
    localparam int R  = 4;

    localparam logic [47:0] MAC2 = 48'h05_00_00_00_00_02;
    localparam logic [47:0] MAC3 = 48'h00_00_00_00_00_A0;
    localparam logic [47:0] UNK  = 48'h00_00_00_00_00_10;
    localparam logic [47:0] BCST = 48'hFF_FF_FF_FF_FF_FF;

    logic clk, rst_n;
    logic cfg_wr_en, cfg_valid;
    logic [2:0]  cfg_addr;
    logic [47:0] cfg_mac;
    logic [R-1:0] cfg_mask;

    logic [DW-1:0] td;
    logic [KW-1:0] tk;
    logic          tv, tl, use1, m_rdy, tog_en;
    logic [IW-1:0] tid_v;
    logic [UW-1:0] tuser_v;

    int n_checks, n_err, cyc;
    logic [DW-1:0] fd [8];
    logic [7:0]    frame_seq;

    logic [DW-1:0] oq_data[$];
    logic          oq_last[$];
    logic [R-1:0]  oq_dest[$];
    logic [IW-1:0] oq_id[$];
    logic [UW-1:0] oq_user[$];
    logic [KW-1:0] oq_keep[$];
    int            oq_cyc[$];
    int            aq_cyc[$];
    logic [R-1:0]  o1_dest[$];

    switch_ingress_tagger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .USER_WIDTH(UW), .DEST_WIDTH(R)) s0 ();
    switch_ingress_tagger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .USER_WIDTH(UW), .DEST_WIDTH(R)) m0 ();
    switch_ingress_tagger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .USER_WIDTH(UW), .DEST_WIDTH(R)) s1 ();
    switch_ingress_tagger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .USER_WIDTH(UW), .DEST_WIDTH(R)) m1 ();

    assign s0.tdata  = td;      assign s1.tdata  = td;
    assign s0.tkeep  = tk;      assign s1.tkeep  = tk;
    assign s0.tlast  = tl;      assign s1.tlast  = tl;
    assign s0.tid    = tid_v;   assign s1.tid    = tid_v;
    assign s0.tuser  = tuser_v; assign s1.tuser  = tuser_v;
    assign s0.tdest  = '0;      assign s1.tdest  = '0;
    assign s0.tvalid = tv & ~use1;
    assign s1.tvalid = tv & use1;
    assign m0.tready = m_rdy;
    assign m1.tready = 1'b1;

`ifdef SWITCH_INGRESS_TAGGER_STATS_EN
    logic [31:0] h0, f0, d0, h1, f1, d1;
`endif

    switch_ingress_tagger #(.AXIS_DATA_WIDTH(DW), .AXIS_ID_WIDTH(IW), .AXIS_USER_WIDTH(UW),
                            .RADIX(R), .PORT_INDEX(0), .TABLE_DEPTH(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_axis(s0), .m_axis(m0),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .cfg_mac(cfg_mac), .cfg_mask(cfg_mask)
`ifdef SWITCH_INGRESS_TAGGER_STATS_EN
        , .stat_hit(h0), .stat_flood(f0), .stat_drop(d0)
`endif
    );

    switch_ingress_tagger #(.AXIS_DATA_WIDTH(DW), .AXIS_ID_WIDTH(IW), .AXIS_USER_WIDTH(UW),
                            .RADIX(R), .PORT_INDEX(1), .TABLE_DEPTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis(s1), .m_axis(m1),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .cfg_mac(cfg_mac), .cfg_mask(cfg_mask)
`ifdef SWITCH_INGRESS_TAGGER_STATS_EN
        , .stat_hit(h1), .stat_flood(f1), .stat_drop(d1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (tog_en) m_rdy = ~m_rdy;
    end

    // Transfers are recorded at the falling edge, half a cycle before the
    // rising edge that completes them.
    always @(negedge clk) begin
        if (rst_n && m0.tvalid && m0.tready) begin
            oq_data.push_back(m0.tdata);
            oq_last.push_back(m0.tlast);
            oq_dest.push_back(m0.tdest);
            oq_id.push_back(m0.tid);
            oq_user.push_back(m0.tuser);
            oq_keep.push_back(m0.tkeep);
            oq_cyc.push_back(cyc);
        end
        if (rst_n && s0.tvalid && s0.tready) aq_cyc.push_back(cyc);
        if (rst_n && m1.tvalid && m1.tready) o1_dest.push_back(m1.tdest);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        oq_data.delete(); oq_last.delete(); oq_dest.delete(); oq_id.delete();
        oq_user.delete(); oq_keep.delete(); oq_cyc.delete(); aq_cyc.delete();
        o1_dest.delete();
    endtask

    task automatic set_frame(input logic [47:0] da);
        frame_seq++;
        fd[0] = {8'hA5, frame_seq, da};
        for (int i = 1; i < 8; i++) fd[i] = {8'hC0, frame_seq, 40'h0, 8'(i)};
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic v, input logic [47:0] mac, input logic [R-1:0] msk);
        cfg_addr = a; cfg_valid = v; cfg_mac = mac; cfg_mask = msk; cfg_wr_en = 1'b1;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [KW-1:0] last_keep);
        int w;
        for (int i = 0; i < n; i++) begin
            tv = 1'b1; td = fd[i]; tl = (i == n - 1);
            tk = (i == n - 1) ? last_keep : 8'hFF;
            tid_v = 8'h10 + 8'(i); tuser_v = 17'h10000 | 17'(i);
            w = 0;
            @(negedge clk);
            while (!(use1 ? s1.tready : s0.tready) && w < 200) begin
                @(negedge clk);
                w++;
            end
            n_checks++;
            assert (w < 200) else begin
                n_err++;
                $error("FAIL send_timeout observed=%0d expected=<200", w);
            end
            @(posedge clk); #1;
        end
        tv = 1'b0; tl = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int n, input logic [R-1:0] dest);
        chk({tag, "_count"}, 64'(oq_data.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < oq_data.size()) begin
                chk($sformatf("%s_dest%0d", tag, i), 64'(oq_dest[i]), 64'(dest));
                chk($sformatf("%s_data%0d", tag, i), oq_data[i], fd[i]);
                chk($sformatf("%s_last%0d", tag, i), 64'(oq_last[i]), 64'(i == n - 1));
            end
        end
    endtask

    initial begin
        n_checks = 0; n_err = 0; cyc = 0; frame_seq = 8'h0;
        rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_mac = '0; cfg_mask = '0;
        tv = 1'b0; td = '0; tk = '0; tl = 1'b0; tid_v = '0; tuser_v = '0;
        use1 = 1'b0; m_rdy = 1'b1; tog_en = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 64'(s0.tready), 64'd0);
        chk("rst_m_tvalid", 64'(m0.tvalid), 64'd0);
        chk("rst_m_tdest", 64'(m0.tdest), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_s_tready", 64'(s0.tready), 64'd1);
        chk("idle_m_tvalid", 64'(m0.tvalid), 64'd0);
        @(posedge clk); #1;

        // Unicast hit, 3 beats
        cfg_write(3'd2, 1'b1, MAC2, 4'b1000);
        clr(); set_frame(MAC2);
        send_frame(3, 8'hFF); idle(6);
        check_frame("hit3", 3, 4'b1000);
        if (oq_cyc.size() > 0 && aq_cyc.size() > 0)
            chk("hit3_latency", 64'(oq_cyc[0] - aq_cyc[0]), 64'd2);
        if (oq_data.size() == 3) begin
            chk("hit3_tid0", 64'(oq_id[0]), 64'h10);
            chk("hit3_tid2", 64'(oq_id[2]), 64'h12);
            chk("hit3_tuser1", 64'(oq_user[1]), 64'h10001);
        end

        // Broadcast on port 1 instance
        clr(); set_frame(BCST); use1 = 1'b1;
        send_frame(1, 8'hFF); idle(6); use1 = 1'b0;
        chk("bcast_count", 64'(o1_dest.size()), 64'd1);
        if (o1_dest.size() > 0) chk("bcast_dest", 64'(o1_dest[0]), 64'b1101);
        chk("bcast_p0_quiet", 64'(oq_data.size()), 64'd0);

        // Unknown unicast floods except own port
        clr(); set_frame(UNK);
        send_frame(2, 8'hFF); idle(6);
        check_frame("unk", 2, 4'b1110);

        // Mask reduces to own port only: whole frame swallowed
        cfg_write(3'd3, 1'b1, MAC3, 4'b0001);
        clr(); set_frame(MAC3);
        send_frame(4, 8'hFF); idle(6);
        chk("hairpin_out", 64'(oq_data.size()), 64'd0);
        chk("hairpin_accepted", 64'(aq_cyc.size()), 64'd4);
        clr(); set_frame(MAC2);
        send_frame(2, 8'hFF); idle(6);
        check_frame("after_drop", 2, 4'b1000);

        // Runt single beat dropped, full single beat forwarded
        clr(); set_frame(MAC2);
        send_frame(1, 8'h0F); idle(6);
        chk("runt_out", 64'(oq_data.size()), 64'd0);
        clr(); set_frame(MAC2);
        send_frame(1, 8'hFF); idle(6);
        check_frame("single", 1, 4'b1000);
        if (oq_keep.size() > 0) chk("single_keep", 64'(oq_keep[0]), 64'hFF);

        // Output backpressure toggling 1010...
        clr(); set_frame(MAC2);
        m_rdy = 1'b1; tog_en = 1'b1;
        send_frame(5, 8'hFF);
        tog_en = 1'b0; m_rdy = 1'b1; idle(6);
        check_frame("bp5", 5, 4'b1000);

        // Config write in the LOOKUP cycle: old mask used
        clr(); set_frame(MAC2);
        tv = 1'b1; td = fd[0]; tk = 8'hFF; tl = 1'b1;
        @(negedge clk);
        chk("lkw_accept_ready", 64'(s0.tready), 64'd1);
        @(posedge clk); #1;
        tv = 1'b0; tl = 1'b0;
        cfg_write(3'd2, 1'b1, MAC2, 4'b0100);
        idle(6);
        check_frame("lkw_old", 1, 4'b1000);
        clr(); set_frame(MAC2);
        send_frame(1, 8'hFF); idle(6);
        check_frame("lkw_new", 1, 4'b0100);

        // Reset mid-frame: partial frame discarded, table invalidated
        clr(); set_frame(MAC2);
        tv = 1'b1; td = fd[0]; tk = 8'hFF; tl = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        tv = 1'b0;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(6);
        chk("midrst_out", 64'(oq_data.size()), 64'd0);
        @(negedge clk);
        chk("midrst_tdest", 64'(m0.tdest), 64'd0);
        @(posedge clk); #1;
        clr(); set_frame(MAC2);
        send_frame(1, 8'hFF); idle(6);
        check_frame("postrst_flood", 1, 4'b1110);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=done", cyc);
        $fatal(1, "timeout");
    end

endmodule
